// File: rtl/mem_bus_arbiter.sv
// Two-master (core M-stage, UART bridge) to one-slave Wishbone arbiter for the data memory.
// Registered ownership with a bounded core burst, abort on request drop, and a transfer timeout.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int CORE_BURST_MAX = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  core_cyc_i,
  input  logic                  core_stb_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_adr_i,
  input  logic [DATA_WIDTH-1:0] core_dat_i,
  input  logic [2:0]            core_funct3_i,
  output logic [DATA_WIDTH-1:0] core_dat_o,
  output logic                  core_ack_o,
  output logic                  core_err_o,
  output logic                  core_stall_o,

  input  logic                  uart_cyc_i,
  input  logic                  uart_stb_i,
  input  logic                  uart_we_i,
  input  logic [ADDR_WIDTH-1:0] uart_adr_i,
  input  logic [DATA_WIDTH-1:0] uart_dat_i,
  output logic [DATA_WIDTH-1:0] uart_dat_o,
  output logic                  uart_ack_o,
  output logic                  uart_err_o,

  output logic                  mem_cyc_o,
  output logic                  mem_stb_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_adr_o,
  output logic [DATA_WIDTH-1:0] mem_dat_o,
  output logic [2:0]            mem_funct3_o,
  input  logic [DATA_WIDTH-1:0] mem_dat_i,
  input  logic                  mem_ack_i,

  output logic [1:0]            grant_o
);

  localparam int SW = $clog2(CORE_BURST_MAX + 1);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] BURST_MAX = SW'(CORE_BURST_MAX);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CORE = 2'b01,
    UART = 2'b10
  } state_t;

  state_t        state, state_d;
  logic [SW-1:0] streak, streak_d;
  logic [TW-1:0] timer, timer_d;
  logic          core_err_q, uart_err_q;
  logic          core_err_d, uart_err_d;

  logic req_core, req_uart, owner_req;
  logic own_core, own_uart;

  assign req_core  = core_cyc_i & core_stb_i;
  assign req_uart  = uart_cyc_i & uart_stb_i;
  assign owner_req = (state == CORE) ? req_core : req_uart;

  always_comb begin
    state_d    = state;
    streak_d   = streak;
    timer_d    = timer;
    core_err_d = 1'b0;
    uart_err_d = 1'b0;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (req_uart && (streak == BURST_MAX)) begin
          state_d  = UART;
          streak_d = '0;
        end else if (req_core) begin
          state_d = CORE;
          if (req_uart)
            streak_d = (streak == BURST_MAX) ? streak : streak + 1'b1;
          else
            streak_d = '0;
        end else if (req_uart) begin
          state_d  = UART;
          streak_d = '0;
        end
      end
      CORE, UART: begin
        // An ack always wins over both the abort and the timeout in the same cycle.
        if (mem_ack_i || !owner_req) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer == TIMER_MAX) begin
          state_d    = IDLE;
          timer_d    = '0;
          core_err_d = (state == CORE);
          uart_err_d = (state == UART);
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      streak     <= '0;
      timer      <= '0;
      core_err_q <= 1'b0;
      uart_err_q <= 1'b0;
    end else begin
      state      <= state_d;
      streak     <= streak_d;
      timer      <= timer_d;
      core_err_q <= core_err_d;
      uart_err_q <= uart_err_d;
    end
  end

  // Ownership is masked by reset so the slave and both masters see a quiet bus while rst is low.
  assign own_core = rst & (state == CORE);
  assign own_uart = rst & (state == UART);

  always_comb begin
    mem_cyc_o    = 1'b0;
    mem_stb_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_adr_o    = '0;
    mem_dat_o    = '0;
    mem_funct3_o = '0;
    if (own_core) begin
      mem_cyc_o    = core_cyc_i;
      mem_stb_o    = core_stb_i;
      mem_we_o     = core_we_i;
      mem_adr_o    = core_adr_i;
      mem_dat_o    = core_dat_i;
      mem_funct3_o = core_funct3_i;
    end else if (own_uart) begin
      mem_cyc_o    = uart_cyc_i;
      mem_stb_o    = uart_stb_i;
      mem_we_o     = uart_we_i;
      mem_adr_o    = uart_adr_i;
      mem_dat_o    = uart_dat_i;
      mem_funct3_o = 3'b010;
    end
  end

  assign core_ack_o   = own_core & mem_ack_i;
  assign uart_ack_o   = own_uart & mem_ack_i;
  assign core_dat_o   = own_core ? mem_dat_i : '0;
  assign uart_dat_o   = own_uart ? mem_dat_i : '0;
  assign core_err_o   = core_err_q;
  assign uart_err_o   = uart_err_q;
  assign core_stall_o = rst & req_core & ~(own_core & mem_ack_i);
  assign grant_o      = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus hand-written
// timeout, reset and abort sequences. Inputs change on negedge, outputs checked 1ns later.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        core_cyc_i, core_stb_i, core_we_i;
  logic [31:0] core_adr_i, core_dat_i;
  logic [2:0]  core_funct3_i;
  logic [31:0] core_dat_o;
  logic        core_ack_o, core_err_o, core_stall_o;
  logic        uart_cyc_i, uart_stb_i, uart_we_i;
  logic [31:0] uart_adr_i, uart_dat_i;
  logic [31:0] uart_dat_o;
  logic        uart_ack_o, uart_err_o;
  logic        mem_cyc_o, mem_stb_o, mem_we_o;
  logic [31:0] mem_adr_o, mem_dat_o;
  logic [2:0]  mem_funct3_o;
  logic [31:0] mem_dat_i;
  logic        mem_ack_i;
  logic [1:0]  grant_o;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .CORE_BURST_MAX(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .core_cyc_i(core_cyc_i), .core_stb_i(core_stb_i), .core_we_i(core_we_i),
    .core_adr_i(core_adr_i), .core_dat_i(core_dat_i), .core_funct3_i(core_funct3_i),
    .core_dat_o(core_dat_o), .core_ack_o(core_ack_o), .core_err_o(core_err_o),
    .core_stall_o(core_stall_o),
    .uart_cyc_i(uart_cyc_i), .uart_stb_i(uart_stb_i), .uart_we_i(uart_we_i),
    .uart_adr_i(uart_adr_i), .uart_dat_i(uart_dat_i), .uart_dat_o(uart_dat_o),
    .uart_ack_o(uart_ack_o), .uart_err_o(uart_err_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_funct3_o(mem_funct3_o),
    .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, c, u, a;
    logic [1:0] g;
    logic       stb, cack, uack, stall;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic u, input logic a);
    @(negedge clk);
    rst        = r;
    core_cyc_i = c;
    core_stb_i = c;
    uart_cyc_i = u;
    uart_stb_i = u;
    mem_ack_i  = a;
    #1;
  endtask

  // Bus contents follow from the expected owner and the fixed per-master stimulus.
  task automatic check_bus(input string tag, input logic [1:0] g, input logic stb,
                           input logic cack, input logic uack, input logic stall,
                           input logic cerr, input logic uerr);
    logic [31:0] e_adr, e_wdat, e_cdat, e_udat;
    logic [2:0]  e_f3;
    logic        e_we;
    e_adr = '0; e_wdat = '0; e_cdat = '0; e_udat = '0; e_f3 = '0; e_we = 1'b0;
    if (g == 2'b01) begin
      e_adr = 32'h10; e_wdat = 32'h1122_3344; e_f3 = 3'b100; e_cdat = 32'hDEAD_BEEF;
    end else if (g == 2'b10) begin
      e_adr = 32'h8; e_wdat = 32'hA5A5_A5A5; e_f3 = 3'b010; e_we = 1'b1; e_udat = 32'hDEAD_BEEF;
    end
    check({tag, " grant"}, {30'd0, grant_o}, {30'd0, g});
    check({tag, " mem_stb"}, {31'd0, mem_stb_o}, {31'd0, stb});
    check({tag, " mem_cyc"}, {31'd0, mem_cyc_o}, {31'd0, stb});
    check({tag, " mem_we"}, {31'd0, mem_we_o}, {31'd0, e_we});
    check({tag, " mem_adr"}, mem_adr_o, e_adr);
    check({tag, " mem_dat"}, mem_dat_o, e_wdat);
    check({tag, " mem_funct3"}, {29'd0, mem_funct3_o}, {29'd0, e_f3});
    check({tag, " core_dat"}, core_dat_o, e_cdat);
    check({tag, " uart_dat"}, uart_dat_o, e_udat);
    check({tag, " core_ack"}, {31'd0, core_ack_o}, {31'd0, cack});
    check({tag, " uart_ack"}, {31'd0, uart_ack_o}, {31'd0, uack});
    check({tag, " core_stall"}, {31'd0, core_stall_o}, {31'd0, stall});
    check({tag, " core_err"}, {31'd0, core_err_o}, {31'd0, cerr});
    check({tag, " uart_err"}, {31'd0, uart_err_o}, {31'd0, uerr});
  endtask

  initial begin
    rst = 1'b0;
    core_cyc_i = 1'b0; core_stb_i = 1'b0; core_we_i = 1'b0;
    core_adr_i = 32'h10; core_dat_i = 32'h1122_3344; core_funct3_i = 3'b100;
    uart_cyc_i = 1'b0; uart_stb_i = 1'b0; uart_we_i = 1'b1;
    uart_adr_i = 32'h8; uart_dat_i = 32'hA5A5_A5A5;
    mem_dat_i = 32'hDEAD_BEEF; mem_ack_i = 1'b0;

    //             r  c  u  a  grant  stb cack uack stall
    vecs[0]  = '{1, 1, 0, 0, 2'b00, 0, 0, 0, 1};  // core read request
    vecs[1]  = '{1, 1, 0, 0, 2'b01, 1, 0, 0, 1};
    vecs[2]  = '{1, 1, 0, 1, 2'b01, 1, 1, 0, 0};  // ack: DEADBEEF to core
    vecs[3]  = '{1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
    vecs[4]  = '{1, 0, 1, 0, 2'b00, 0, 0, 0, 0};  // uart write
    vecs[5]  = '{1, 0, 1, 0, 2'b10, 1, 0, 0, 0};
    vecs[6]  = '{1, 0, 1, 1, 2'b10, 1, 0, 1, 0};
    vecs[7]  = '{1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
    vecs[8]  = '{1, 1, 1, 0, 2'b00, 0, 0, 0, 1};  // both: core x4 then uart
    vecs[9]  = '{1, 1, 1, 1, 2'b01, 1, 1, 0, 0};
    vecs[10] = '{1, 1, 1, 0, 2'b00, 0, 0, 0, 1};
    vecs[11] = '{1, 1, 1, 1, 2'b01, 1, 1, 0, 0};
    vecs[12] = '{1, 1, 1, 0, 2'b00, 0, 0, 0, 1};
    vecs[13] = '{1, 1, 1, 1, 2'b01, 1, 1, 0, 0};
    vecs[14] = '{1, 1, 1, 0, 2'b00, 0, 0, 0, 1};
    vecs[15] = '{1, 1, 1, 1, 2'b01, 1, 1, 0, 0};
    vecs[16] = '{1, 1, 1, 0, 2'b00, 0, 0, 0, 1};
    vecs[17] = '{1, 1, 1, 0, 2'b10, 1, 0, 0, 1};
    vecs[18] = '{1, 1, 1, 1, 2'b10, 1, 0, 1, 1};
    vecs[19] = '{1, 1, 1, 0, 2'b00, 0, 0, 0, 1};
    vecs[20] = '{1, 1, 0, 1, 2'b01, 1, 1, 0, 0};
    vecs[21] = '{1, 0, 0, 0, 2'b00, 0, 0, 0, 0};

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check_bus("reset", 2'b00, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].c, vecs[i].u, vecs[i].a);
      check_bus($sformatf("vec%0d", i), vecs[i].g, vecs[i].stb, vecs[i].cack,
                vecs[i].uack, vecs[i].stall, 1'b0, 1'b0);
    end

    // Slave never acks: err after 16 owned cycles, then a uart request is granted.
    step(1, 1, 0, 0);
    check_bus("to_req", 2'b00, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 0);
      check_bus($sformatf("to_wait%0d", i), 2'b01, 1, 0, 0, 1, 0, 0);
    end
    step(1, 0, 1, 0);
    check_bus("to_err", 2'b00, 0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 1);
    check_bus("to_uart", 2'b10, 1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_bus("to_idle", 2'b00, 0, 0, 0, 0, 0, 0);

    // Ack in the final timeout cycle wins: no err.
    step(1, 1, 0, 0);
    check_bus("aw_req", 2'b00, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(1, 1, 0, 0);
      check_bus($sformatf("aw_wait%0d", i), 2'b01, 1, 0, 0, 1, 0, 0);
    end
    step(1, 1, 0, 1);
    check_bus("aw_ack", 2'b01, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    check_bus("aw_noerr", 2'b00, 0, 0, 0, 0, 0, 0);

    // Reset while the uart transfer is outstanding.
    step(1, 0, 1, 0);
    check_bus("rs_req", 2'b00, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0);
    check_bus("rs_own", 2'b10, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("rs_low mem_stb", {31'd0, mem_stb_o}, 32'd0);
    check("rs_low uart_ack", {31'd0, uart_ack_o}, 32'd0);
    check("rs_low uart_err", {31'd0, uart_err_o}, 32'd0);
    step(1, 0, 0, 0);
    check_bus("rs_after", 2'b00, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0);
    check_bus("rs_core_req", 2'b00, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1);
    check_bus("rs_core_ack", 2'b01, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    check_bus("rs_idle", 2'b00, 0, 0, 0, 0, 0, 0);

    // Uart drops stb before ack while the core waits.
    step(1, 0, 1, 0);
    check_bus("ab_req", 2'b00, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0);
    check_bus("ab_own", 2'b10, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0);
    check_bus("ab_drop", 2'b10, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0);
    check_bus("ab_idle", 2'b00, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1);
    check_bus("ab_core", 2'b01, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    check_bus("ab_end", 2'b00, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares one mem_byte instance (data memory) between the core's M-stage port and the UART Wishbone bridge.
- Replaces the static i_select_mem mux with cycle-accurate ownership.
- Stalls the core while the UART bridge holds the bus.
- Terminates hung transfers with a timeout error.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- CORE_BURST_MAX, 4, consecutive core grants allowed while the UART is pending before the UART is forced to win.
- TIMEOUT_CYCLES, 16, cycles without mem_ack_i before a granted transfer is aborted (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- core_cyc_i  in  1  core bus cycle.
- core_stb_i  in  1  core strobe.
- core_we_i  in  1  core write enable.
- core_adr_i  in  ADDR_WIDTH  core address.
- core_dat_i  in  DATA_WIDTH  core write data.
- core_funct3_i  in  3  core access size/sign.
- core_dat_o  out  DATA_WIDTH  read data to core.
- core_ack_o  out  1  core transfer done.
- core_err_o  out  1  core transfer timed out.
- core_stall_o  out  1  core must hold the M stage.
- uart_cyc_i  in  1  bridge cycle.
- uart_stb_i  in  1  bridge strobe.
- uart_we_i  in  1  bridge write enable.
- uart_adr_i  in  ADDR_WIDTH  bridge address.
- uart_dat_i  in  DATA_WIDTH  bridge write data.
- uart_dat_o  out  DATA_WIDTH  read data to bridge.
- uart_ack_o  out  1  bridge transfer done.
- uart_err_o  out  1  bridge transfer timed out.
- mem_cyc_o  out  1  slave cycle.
- mem_stb_o  out  1  slave strobe.
- mem_we_o  out  1  slave write enable.
- mem_adr_o  out  ADDR_WIDTH  slave address.
- mem_dat_o  out  DATA_WIDTH  slave write data.
- mem_funct3_o  out  3  slave access size.
- mem_dat_i  in  DATA_WIDTH  slave read data.
- mem_ack_i  in  1  slave acknowledge.
- grant_o  out  2  current owner: 00 none, 01 core, 10 uart.

Behaviour:
- Request definitions: req_core = core_cyc_i & core_stb_i; req_uart = uart_cyc_i & uart_stb_i.
- FSM states: IDLE, CORE, UART. State, grant_o, counters and all err outputs are registered.
- Reset (rst=0 at a clock edge): state IDLE, grant_o=00, streak=0, timer=0. All mem_* outputs 0, all acks/errs 0, core_stall_o=0.
- Reset mid-transfer: the transfer is dropped, no ack/err is issued, the slave sees stb=0 on the next cycle.
- IDLE arbitration, first match wins:
  - req_uart & streak==CORE_BURST_MAX -> UART, streak cleared.
  - req_core -> CORE; streak increments (saturating) if req_uart, else streak clears.
  - req_uart -> UART, streak cleared.
  - otherwise stay in IDLE.
- Grant latency: a request sampled at edge N becomes owner from edge N; mem_stb_o is asserted in the cycle after N (registered grant, one-cycle arbitration latency).
- While owning, mem_* is a combinational mux of the owner's signals. mem_funct3_o = core_funct3_i for the core, 3'b010 for the UART.
- Ack/data return: owner_ack_o = mem_ack_i, combinational. owner_dat_o = mem_dat_i. The non-owner sees ack=0 and dat=0.
- On a mem_ack_i edge: return to IDLE, giving one turnaround cycle with mem_stb_o=0 between any two transfers.
- Owner deasserting stb/cyc before ack: abort, return to IDLE next edge, no ack.
- Timeout: timer counts owned cycles without ack. When timer reaches TIMEOUT_CYCLES-1 with no ack, owner_err_o pulses for exactly 1 cycle and the FSM returns to IDLE. An ack in that same cycle wins and no err is raised.
- core_stall_o = req_core & ~(state==CORE & mem_ack_i). It is high in the IDLE arbitration cycle, during UART ownership, and while waiting on the slave.
- Simultaneous first requests: the core wins, since streak starts at 0.
- UART starvation bound: at most CORE_BURST_MAX core transfers can complete ahead of a pending UART request.
- Widths: the address passes through unmodified. Truncation to memory depth is the slave side's job.

Test Plan:
- Core only, slave acks 1 cycle after stb: core load to 0x10 returning 0xDEADBEEF.
  - Required: grant_o=01 one cycle after request, core_ack_o for 1 cycle, core_dat_o=0xDEADBEEF, stall low in the ack cycle.
- UART write 0xA5A5A5A5 to 0x8 while the core is idle.
  - Required: mem_we_o=1, mem_funct3_o=010, uart_ack_o pulse, core_ack_o stays 0.
- Both request continuously, CORE_BURST_MAX=4.
  - Required: grant sequence core, core, core, core, uart, with a mem_stb_o=0 turnaround between each; core_stall_o high throughout UART ownership.
- Slave never acks, TIMEOUT_CYCLES=16.
  - Required: core_err_o pulses exactly 16 owned cycles after grant; FSM IDLE next cycle; a following UART request is granted.
- rst=0 asserted while the UART transfer is outstanding.
  - Required: next cycle mem_stb_o=0, grant_o=00, no uart_ack_o/uart_err_o; normal arbitration after release.
- UART drops stb before ack.
  - Required: mem_stb_o=0 next cycle, no ack, a pending core request is granted on the following edge.
